// File: rtl/pe_sum_collector.sv
// Output-side collector for one pe: requantizes 36-bit sums to 16-bit, buffers them, drains over valid/ready.
// Optional round-half-up before the shift is enabled by defining COLLECT_ROUND_EN (default: truncate).
module pe_sum_collector #(
    parameter int unsigned SUM_W      = 36,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FRAC_SHIFT = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FRAME_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [SUM_W-1:0]           sum,
    input  logic                       calc_done,
    output logic [OUT_W-1:0]           res_data,
    output logic                       res_sat,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    input  logic                       clr_ovf,
    output logic                       frame_done
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = $clog2(FRAME_LEN + 1);

    localparam logic signed [SUM_W:0] Q_MAX = {{(SUM_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SUM_W:0] Q_MIN = {{(SUM_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
`ifdef COLLECT_ROUND_EN
    localparam logic signed [SUM_W:0] RND = {{SUM_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
`endif

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, LAST} state_t;

    logic signed [SUM_W:0] s_ext;
    logic signed [SUM_W:0] s_adj;
    logic signed [SUM_W:0] q;
    entry_t                new_ent;

    entry_t                mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  push;
    logic                  pop;
    logic                  wr_ok;

    state_t                state;
    state_t                state_nxt;
    logic [FCNT_W-1:0]     fcnt;
    logic [FCNT_W-1:0]     fcnt_nxt;
    logic                  fdone_nxt;

    // Requantize: widen by one bit so the optional round term can never wrap, then shift and clamp.
    always_comb begin
        s_ext = {sum[SUM_W-1], sum};
`ifdef COLLECT_ROUND_EN
        s_adj = s_ext + RND;
`else
        s_adj = s_ext;
`endif
        q            = s_adj >>> FRAC_SHIFT;
        new_ent.sat  = 1'b0;
        new_ent.data = q[OUT_W-1:0];
        if (q > Q_MAX) begin
            new_ent.sat  = 1'b1;
            new_ent.data = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (q < Q_MIN) begin
            new_ent.sat  = 1'b1;
            new_ent.data = {1'b1, {(OUT_W - 1){1'b0}}};
        end
    end

    assign push      = calc_done & en;
    assign pop       = res_valid & res_ready;
    assign wr_ok     = push & ((count < CNT_W'(DEPTH)) | pop);
    assign rd_nxt    = rd_ptr + PTR_W'(1);
    assign count_nxt = count + CNT_W'(wr_ok) - CNT_W'(pop);

    // Storage array carries no reset; the head register below is what the outputs see.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= new_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            count     <= count_nxt;
            res_valid <= (count_nxt != '0);
            // Show-ahead head: next stored entry if one remains, else the incoming one; otherwise hold.
            if (pop && count >= CNT_W'(2)) begin
                res_data <= mem[rd_nxt].data;
                res_sat  <= mem[rd_nxt].sat;
            end else if (wr_ok && (pop || count == '0)) begin
                res_data <= new_ent.data;
                res_sat  <= new_ent.sat;
            end
            if (push && !wr_ok) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Frame tracking: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            fcnt       <= fcnt_nxt;
            frame_done <= fdone_nxt;
        end
    end

    // Frame tracking: next state; LAST is the cycle frame_done is asserted.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        fdone_nxt = 1'b0;
        if (state == LAST) begin
            state_nxt = IDLE;
        end
        if (pop) begin
            if (fcnt == FCNT_W'(FRAME_LEN - 1)) begin
                state_nxt = LAST;
                fcnt_nxt  = '0;
                fdone_nxt = 1'b1;
            end else begin
                state_nxt = DRAIN;
                fcnt_nxt  = fcnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_sum_collector.sv
// Self-checking bench for pe_sum_collector: directed scenarios plus randomized traffic against a queue model.
module tb_pe_sum_collector;

    localparam int SUM_W = 36;
    localparam int OUT_W = 16;
    localparam int FS    = 8;
    localparam int DEPTH = 4;
    localparam int FL    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [SUM_W-1:0] sum;
    logic             calc_done;
    logic [OUT_W-1:0] res_data;
    logic             res_sat;
    logic             res_valid;
    logic             res_ready;
    logic [2:0]       count;
    logic             ovf;
    logic             clr_ovf;
    logic             frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: queue of {sat, data}, sticky overflow, frame progress
    logic [16:0] mq[$];
    bit          m_ovf;
    int          m_fcnt;
    bit          m_fdone;

    pe_sum_collector dut (
        .clk(clk), .rst(rst), .en(en), .sum(sum), .calc_done(calc_done),
        .res_data(res_data), .res_sat(res_sat), .res_valid(res_valid), .res_ready(res_ready),
        .count(count), .ovf(ovf), .clr_ovf(clr_ovf), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_q(input logic [SUM_W-1:0] s);
        longint      v;
        longint      qv;
        logic [63:0] qb;
        v = $signed(s);
`ifdef COLLECT_ROUND_EN
        v = v + (64'sd1 <<< (FS - 1));
`endif
        qv = v >>> FS;
        if (qv > 32767) return {1'b1, 16'h7FFF};
        if (qv < -32768) return {1'b1, 16'h8000};
        qb = qv;
        return {1'b0, qb[15:0]};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf   = 0;
        m_fcnt  = 0;
        m_fdone = 0;
    endtask

    // One clock with the currently driven inputs; the model advances by the same edge.
    task automatic step();
        bit pop;
        bit push;
        bit full;
        pop  = (mq.size() > 0) && res_ready;
        push = calc_done && en;
        full = (mq.size() >= DEPTH) && !pop;
        m_fdone = 0;
        if (pop) begin
            void'(mq.pop_front());
            m_fcnt++;
            if (m_fcnt == FL) begin
                m_fcnt  = 0;
                m_fdone = 1;
            end
        end
        if (push && !full) mq.push_back(ref_q(sum));
        if (push && full) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; calc_done = 1'b0; sum = '0; res_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic push_one(input logic [SUM_W-1:0] s);
        calc_done = 1'b1; sum = s; res_ready = 1'b0;
        step();
        calc_done = 1'b0;
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (res_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", res_data); end
        if (res_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", res_sat); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    endtask

    task automatic test_unity();
        calc_done = 1'b1; sum = 36'h0_0001_0000; res_ready = 1'b1;
        step();
        calc_done = 1'b0;
        checks += 3;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL unity_valid got=%b exp=1", res_valid); end
        if (res_data !== 16'h0100) begin errors++; $display("FAIL unity_data got=%h exp=0100", res_data); end
        if (res_sat !== 1'b0) begin errors++; $display("FAIL unity_sat got=%b exp=0", res_sat); end
        pop_one();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL unity_empty got=%b exp=0", res_valid); end
    endtask

    task automatic test_negative();
        push_one(36'hF_FFFF_0000);
        checks += 2;
        if (res_data !== 16'hFF00) begin errors++; $display("FAIL neg_data got=%h exp=ff00", res_data); end
        if (res_sat !== 1'b0) begin errors++; $display("FAIL neg_sat got=%b exp=0", res_sat); end
        pop_one();
    endtask

    task automatic test_saturation();
        push_one(36'h0_7FFF_FFFF);
        push_one(36'h8_0000_0000);
        checks += 3;
        if (count !== 3'd2) begin errors++; $display("FAIL sat_count got=%0d exp=2", count); end
        if (res_data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_data got=%h exp=7fff", res_data); end
        if (res_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got=%b exp=1", res_sat); end
        pop_one();
        checks += 2;
        if (res_data !== 16'h8000) begin errors++; $display("FAIL sat_neg_data got=%h exp=8000", res_data); end
        if (res_sat !== 1'b1) begin errors++; $display("FAIL sat_neg_flag got=%b exp=1", res_sat); end
        pop_one();
    endtask

    task automatic test_rounding();
        logic [15:0] exp_d;
`ifdef COLLECT_ROUND_EN
        exp_d = 16'h0002;
`else
        exp_d = 16'h0001;
`endif
        push_one(36'h0_0000_0180);
        checks++;
        if (res_data !== exp_d) begin errors++; $display("FAIL round_data got=%h exp=%h", res_data, exp_d); end
        pop_one();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) push_one(SUM_W'(i * 256));
        checks += 2;
        if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (res_data !== 16'(i)) begin errors++; $display("FAIL ovf_order%0d got=%h exp=%h", i, res_data, 16'(i)); end
            pop_one();
            checks++;
            if (frame_done !== (i == 4)) begin errors++; $display("FAIL ovf_frame_done%0d got=%b exp=%b", i, frame_done, i == 4); end
        end
        step();
        checks += 2;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL ovf_frame_done_pulse got=%b exp=0", frame_done); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", res_valid); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) push_one(SUM_W'(i * 256));
        pop_one();
        pop_one();
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", res_valid); end
        if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) push_one(SUM_W'((i + 7) * 256));
        for (int i = 0; i < 4; i++) begin
            pop_one();
            checks++;
            if (frame_done !== (i == 3)) begin errors++; $display("FAIL midrst_frame_done%0d got=%b exp=%b", i, frame_done, i == 3); end
        end
    endtask

    task automatic test_random();
        logic [63:0] r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            en        = ($urandom % 4) != 0;
            calc_done = $urandom % 2;
            res_ready = ($urandom % 3) != 0;
            clr_ovf   = ($urandom % 16) == 0;
            r         = {$urandom, $urandom};
            if ($urandom % 3 == 0) sum = r[SUM_W-1:0];
            else sum = SUM_W'($signed(r[23:0]));
            step();
            checks += 4;
            if (res_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, res_valid, mq.size() > 0); end
            if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, count, mq.size()); end
            if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", n, ovf, m_ovf); end
            if (frame_done !== m_fdone) begin errors++; $display("FAIL rnd_frame_done cyc=%0d got=%b exp=%b", n, frame_done, m_fdone); end
            if (mq.size() > 0) begin
                checks++;
                if ({res_sat, res_data} !== mq[0]) begin
                    errors++;
                    $display("FAIL rnd_head cyc=%0d got=%b/%h exp=%b/%h", n, res_sat, res_data, mq[0][16], mq[0][15:0]);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_clear();
        test_reset();
        test_unity();
        test_negative();
        test_saturation();
        test_rounding();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
